// File: rtl/sigmoid_table_loader.sv
`timescale 1ns/1ps
// sigmoid_table_loader
// Streams NUM_ENTRIES table values from a valid/ready source into a 32-entry
// register bank, starting at BASE_ADDR and wrapping modulo 32. Each accepted
// entry becomes a registered write one cycle later; done pulses with the last
// write. abort drops an in-progress load without issuing a further write.
module sigmoid_table_loader #(
  parameter int NUM_ENTRIES = 32,
  parameter int BASE_ADDR   = 0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       src_valid,
  input  logic [3:0] src_data,
  output logic       src_ready,
  output logic       write_en,
  output logic [4:0] address_out,
  output logic [3:0] data_out,
  output logic       busy,
  output logic       done
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // IDLE    | waiting for start; source is not accepted
  // LOAD    | accepting entries, one register write per accepted entry
  // DONE    | single cycle carrying the final write and the done pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the low five bits of the base matter because the bank wraps at 32.
  localparam logic [4:0] BASE     = 5'(BASE_ADDR);
  localparam logic [5:0] LAST_IDX = 6'(NUM_ENTRIES - 1);

  state_e     state_q, state_d;
  logic [5:0] index_q, index_d;
  logic       write_en_q, write_en_d;
  logic [4:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       xfer;

  // abort takes precedence over a transfer in the same cycle, so it gates ready.
  assign src_ready = (state_q == ST_LOAD) && !abort;
  assign xfer      = src_valid && src_ready;

  // Next-state and write-pipeline logic; address/data hold unless a transfer occurs.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    write_en_d = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          index_d = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          write_en_d = 1'b1;
          addr_d     = BASE + index_q[4:0];
          data_d     = src_data;
          index_d    = index_q + 6'd1;
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered write outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      write_en_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      write_en_q <= write_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign write_en    = write_en_q;
  assign address_out = addr_q;
  assign data_out    = data_q;
  assign busy        = (state_q == ST_LOAD);
  assign done        = (state_q == ST_DONE);

endmodule

// File: doc/sigmoid_table_loader.md
SIGMOID_TABLE_LOADER -- requirements
Module: sigmoid_table_loader

Interface
REQ-001 The parameter NUM_ENTRIES SHALL default to 32 and SHALL set the number of table entries written per load (legal range 1..32).
REQ-002 The parameter BASE_ADDR SHALL default to 0 and SHALL set the register address used for the first entry (legal range 0..31).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a single-cycle request to begin a load.
REQ-006 abort  input  1  SHALL terminate an in-progress load.
REQ-007 src_valid  input  1  SHALL indicate that src_data holds a table entry.
REQ-008 src_data  input  4  SHALL carry the table entry value.
REQ-009 src_ready  output  1  SHALL indicate that the loader accepts src_data this cycle.
REQ-010 write_en  output  1  SHALL be the register-bank write strobe.
REQ-011 address_out  output  5  SHALL be the register-bank write address.
REQ-012 data_out  output  4  SHALL be the register-bank write data.
REQ-013 busy  output  1  SHALL be high while a load is in progress.
REQ-014 done  output  1  SHALL be a one-cycle pulse marking completion of a full load.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD and clear the 6-bit entry index to 0 on the same edge.
REQ-017 start SHALL be ignored in LOAD and in DONE.
REQ-018 src_ready SHALL be combinational, equal to (state==LOAD) AND NOT abort.
REQ-019 A transfer SHALL occur in a cycle where src_valid=1 and src_ready=1; data offered while src_ready=0 SHALL be neither consumed nor written.
REQ-020 Each transfer SHALL produce exactly one write on the following cycle (latency 1): write_en=1, address_out=(BASE_ADDR+index) mod 32, data_out=src_data as sampled; the index SHALL then increment.
REQ-021 write_en, address_out and data_out SHALL be registered outputs; write_en SHALL be high only in the cycle after a transfer.
REQ-022 address_out and data_out SHALL hold their last values while write_en=0.
REQ-023 Back-to-back transfers SHALL yield back-to-back write cycles; gaps in src_valid SHALL pause the load without limit.
REQ-024 The transfer with index NUM_ENTRIES-1 SHALL move the FSM to DONE on the same edge, so src_ready=0 in the following cycle.
REQ-025 DONE SHALL last one cycle with done=1 (it coincides with the final write cycle); the FSM SHALL then return to IDLE.
REQ-026 busy SHALL equal (state==LOAD).
REQ-027 abort=1 in LOAD SHALL force IDLE on the next edge with no transfer that cycle; the following cycle SHALL have write_en=0 and done=0; index and registered outputs are otherwise unchanged.
REQ-028 abort SHALL have no effect in IDLE or DONE.
REQ-029 The address SHALL wrap modulo 32 (for example, BASE_ADDR=30 gives addresses 30, 31, 0, 1, ...).

Reset
REQ-030 n_rst=0 SHALL immediately force IDLE, index=0, write_en=0, address_out=0, data_out=0, busy=0 and done=0, independent of clk.
REQ-031 Reset asserted mid-load SHALL discard the load; after release, the FSM SHALL remain in IDLE until a new start.

Verification
REQ-032 Reset, start, then src_valid=1 for 32 cycles with values k mod 16 -> 32 consecutive writes, address k and data k mod 16; done=1 with the address-31 write; busy falls after the last transfer.
REQ-033 BASE_ADDR=30, NUM_ENTRIES=4, data 1,2,3,4 -> writes (30,1), (31,2), (0,3), (1,4), then one done pulse.
REQ-034 src_valid toggled 1/0 each cycle during a load -> a write occurs only in the cycle after each valid cycle, the index advances only on transfers, and done follows the 32nd transfer.
REQ-035 abort asserted together with src_valid after 5 transfers -> no 6th write, done stays 0, FSM returns to IDLE; a new start rewrites from BASE_ADDR.
REQ-036 n_rst pulsed low mid-load (between clock edges) -> outputs go to 0 at once; start asserted during LOAD -> no restart, and the index is unaffected.
